// File: rtl/pipe_pkg.sv
// Shared definitions for the toggle-handshake pipeline stages:
// the producer-side state encoding and the default data width.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Producer side of stage_buffer: idle, waiting for a word to keep,
  // or waiting for a word that a flush already made stale.
  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_WAIT    = 2'd1,
    P_DISCARD = 2'd2
  } prod_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser, asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give a metastable first stage a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/stage_buffer.sv
// stage_buffer: prefetch buffer between two toggle-handshake pipeline stages.
// Pulls words from the producer ahead of demand (up to DEPTH stored) and
// serves consumer requests from local storage. A synchronous flush drops all
// stored words and marks any in-flight producer word for discard.
//
// Build option: define STAGE_BUFFER_SYNC_EN to pass triggerIn and readyIn
// through two-flop synchronisers. Without it both inputs must already be
// synchronous to clk.
//
// Handshake (two-phase, both sides): a requester toggles its trigger line;
// the responder acknowledges by copying that level onto its ready line.
// Consumer side: a request is pending while triggerIn != readyOut; serving it
// updates dataOut and sets readyOut = triggerIn on the same edge.
// Producer side: a fetch is outstanding while readyIn != triggerOut; the
// producer sets readyIn = triggerOut with dataIn valid and holds dataIn
// stable until the next triggerOut toggle.
module stage_buffer
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       triggerIn,
  output logic                       readyOut,
  output logic [WIDTH-1:0]           dataOut,
  output logic                       triggerOut,
  input  logic                       readyIn,
  input  logic [WIDTH-1:0]           dataIn,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [1:0]                 prod_state
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic trig_s;
  logic rdy_s;

`ifdef STAGE_BUFFER_SYNC_EN
  // dataIn needs no synchroniser: it is only sampled after the synchronised
  // completion, by which time the stability rule has held it for two cycles.
  sync_2ff u_sync_trig (
    .clk   (clk),
    .rst_n (reset),
    .d     (triggerIn),
    .q     (trig_s)
  );

  sync_2ff u_sync_rdy (
    .clk   (clk),
    .rst_n (reset),
    .d     (readyIn),
    .q     (rdy_s)
  );
`else
  assign trig_s = triggerIn;
  assign rdy_s  = readyIn;
`endif

  prod_state_e state;
  prod_state_e state_next;
  logic        trig_out_next;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic resp_done;
  logic req_pending;
  logic push;
  logic pop;

  assign resp_done   = (rdy_s == triggerOut);
  assign req_pending = (trig_s != readyOut);

  // Flush wins over both sides: nothing is stored or served in a flush cycle.
  assign push = (state == P_WAIT) && resp_done && !flush;
  // Served only from stored words, never bypassed straight from dataIn.
  assign pop  = req_pending && (count != '0) && !flush;

  assign prod_state = state;

  // Producer FSM next state: at most one fetch in flight, so in P_IDLE the
  // stored count alone decides whether a slot is free.
  always_comb begin
    state_next    = state;
    trig_out_next = triggerOut;
    case (state)
      P_IDLE: begin
        if (!flush && (count < CNT_W'(DEPTH))) begin
          trig_out_next = ~triggerOut;
          state_next    = P_WAIT;
        end
      end
      P_WAIT: begin
        if (flush) begin
          state_next = P_DISCARD;
        end else if (resp_done) begin
          state_next = P_IDLE;
        end
      end
      P_DISCARD: begin
        if (resp_done) begin
          state_next = P_IDLE;
        end
      end
      default: state_next = P_IDLE;
    endcase
  end

  // Producer FSM state and request line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= P_IDLE;
      triggerOut <= 1'b0;
    end else begin
      state      <= state_next;
      triggerOut <= trig_out_next;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dataIn;
    end
  end

  // Pointers and occupancy; a flush empties the buffer by catching rd_ptr up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Consumer response: dataOut and readyOut move together on a serve.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readyOut <= 1'b0;
      dataOut  <= '0;
    end else if (pop) begin
      readyOut <= ~readyOut;
      dataOut  <= mem[rd_ptr];
    end
  end

endmodule
